// File: rtl/data_memory_pkg.sv
// -----------------------------------------------------------------------------
// dm_pkg : shared types and constants for the data_memory block.
//   dm_ctrl_e      - funct3 load/store access type (B, H, W, BU, HU)
//   DM_WORD_BYTES  - bytes per RAM word
//   dm_ctrl_legal  - 1 when a funct3 value names a supported access type
// -----------------------------------------------------------------------------
package dm_pkg;

   typedef enum logic [2:0] {
      DM_B  = 3'b000,
      DM_H  = 3'b001,
      DM_W  = 3'b010,
      DM_BU = 3'b100,
      DM_HU = 3'b101
   } dm_ctrl_e;

   localparam int DM_WORD_BYTES = 4;

   function automatic logic dm_ctrl_legal(input logic [2:0] ctrl);
      case (ctrl)
         DM_B, DM_H, DM_W, DM_BU, DM_HU: return 1'b1;
         default:                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/data_memory_if.sv
// -----------------------------------------------------------------------------
// data_memory_if : load/store bus between the core datapath and data_memory.
//   Address     - byte address (ALU result)
//   DataWr      - store data (rs2)
//   DMWr        - store enable
//   DMCtrl      - funct3 access type
//   DataRd      - extended load result
//   Misaligned  - current access misaligned
//   OutOfRange  - current access outside the RAM window
//   FaultSticky - a faulting store has been seen since reset
//   FaultAddr   - address of the first faulting store
// master = core side, slave = memory side.
// -----------------------------------------------------------------------------
interface data_memory_if;
   logic [31:0] Address;
   logic [31:0] DataWr;
   logic        DMWr;
   logic [2:0]  DMCtrl;
   logic [31:0] DataRd;
   logic        Misaligned;
   logic        OutOfRange;
   logic        FaultSticky;
   logic [31:0] FaultAddr;

   modport master (
      output Address, DataWr, DMWr, DMCtrl,
      input  DataRd, Misaligned, OutOfRange, FaultSticky, FaultAddr
   );

   modport slave (
      input  Address, DataWr, DMWr, DMCtrl,
      output DataRd, Misaligned, OutOfRange, FaultSticky, FaultAddr
   );
endinterface

// File: rtl/dm_load_extend.sv
// -----------------------------------------------------------------------------
// dm_load_extend : picks a byte/half/word out of a 32-bit RAM word and
// sign- or zero-extends it according to the funct3 access type.
// Purely combinational.
//   word_i  - addressed 32-bit word
//   lane_i  - byte lane within the word (already alignment-adjusted)
//   ctrl_i  - funct3 access type; unsupported codes give 0
//   data_o  - extended load result
// -----------------------------------------------------------------------------
module dm_load_extend
   import dm_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  lane_i,
   input  logic [2:0]  ctrl_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[7:0];
      case (lane_i)
         2'd0: byte_sel = word_i[7:0];
         2'd1: byte_sel = word_i[15:8];
         2'd2: byte_sel = word_i[23:16];
         2'd3: byte_sel = word_i[31:24];
         default: byte_sel = word_i[7:0];
      endcase
      half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

      data_o = 32'h0;
      case (ctrl_i)
         DM_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
         DM_BU:   data_o = {24'h0, byte_sel};
         DM_H:    data_o = {{16{half_sel[15]}}, half_sel};
         DM_HU:   data_o = {16'h0, half_sel};
         DM_W:    data_o = word_i;
         default: data_o = 32'h0;
      endcase
   end

endmodule

// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory : word-organised data RAM for the single-cycle RV32I core.
// Combinational read, synchronous write, byte/half/word stores,
// sign/zero-extended loads, range and alignment checks, and a sticky
// capture of the first faulting store.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (clears RAM and fault capture)
//   bus  - data_memory_if.slave (Address, DataWr, DMWr, DMCtrl in;
//          DataRd, Misaligned, OutOfRange, FaultSticky, FaultAddr out)
// Parameters: DEPTH (words, power of two 4..4096), BASE_ADDR (byte address
// of word 0, DEPTH*4 aligned).
// Build option: define DM_MISALIGN_TRAP_EN to flag and trap misaligned
// accesses; otherwise misaligned addresses are truncated to natural alignment.
// -----------------------------------------------------------------------------
module data_memory
   import dm_pkg::*;
#(
   parameter int          DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst,
   data_memory_if.slave  bus
);

   localparam int          IDX_W = $clog2(DEPTH);
   localparam logic [31:0] SPAN  = 32'(DEPTH * DM_WORD_BYTES);

   logic [31:0]      mem_q [DEPTH];
   logic             fault_sticky_q;
   logic [31:0]      fault_addr_q;

   logic [31:0]      off;
   logic             out_of_range;
   logic             legal;
   logic             misaligned;
   logic [1:0]       raw_lane;
   logic [1:0]       lane;
   logic [IDX_W-1:0] idx;
   logic [31:0]      rd_word;
   logic [31:0]      ext_data;
   logic [31:0]      wr_word_d;
   logic             wr_en;
   logic             fault;
   logic             is_half;
   logic             is_word;

   // A single compare on the offset covers the top; the explicit
   // below-base test stops the subtraction from wrapping into range.
   assign off          = bus.Address - BASE_ADDR;
   assign out_of_range = (bus.Address < BASE_ADDR) || (off >= SPAN);
   assign idx          = off[IDX_W+1:2];
   assign raw_lane     = off[1:0];
   assign legal        = dm_ctrl_legal(bus.DMCtrl);
   assign is_half      = (bus.DMCtrl == DM_H) || (bus.DMCtrl == DM_HU);
   assign is_word      = (bus.DMCtrl == DM_W);

`ifdef DM_MISALIGN_TRAP_EN
   assign misaligned = legal && ((is_half && raw_lane[0]) ||
                                 (is_word && (raw_lane != 2'b00)));
   assign lane       = raw_lane;
`else
   // Without the trap, drop the low address bits the access size ignores.
   assign misaligned = 1'b0;
   assign lane       = is_word ? 2'b00 :
                       is_half ? {raw_lane[1], 1'b0} : raw_lane;
`endif

   assign rd_word = mem_q[idx];

   dm_load_extend u_load_extend (
      .word_i (rd_word),
      .lane_i (lane),
      .ctrl_i (bus.DMCtrl),
      .data_o (ext_data)
   );

   // Store merge: start from the current word so untouched lanes survive.
   always_comb begin
      wr_word_d = rd_word;
      case (bus.DMCtrl)
         DM_B, DM_BU: begin
            case (lane)
               2'd0: wr_word_d[7:0]   = bus.DataWr[7:0];
               2'd1: wr_word_d[15:8]  = bus.DataWr[7:0];
               2'd2: wr_word_d[23:16] = bus.DataWr[7:0];
               2'd3: wr_word_d[31:24] = bus.DataWr[7:0];
               default: wr_word_d = rd_word;
            endcase
         end
         DM_H, DM_HU: begin
            if (lane[1]) wr_word_d[31:16] = bus.DataWr[15:0];
            else         wr_word_d[15:0]  = bus.DataWr[15:0];
         end
         DM_W:    wr_word_d = bus.DataWr;
         default: wr_word_d = rd_word;
      endcase
   end

   assign wr_en = bus.DMWr && legal && !out_of_range && !misaligned;
   assign fault = bus.DMWr && (out_of_range || misaligned || !legal);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
         fault_sticky_q <= 1'b0;
         fault_addr_q   <= 32'h0;
      end else begin
         if (wr_en) mem_q[idx] <= wr_word_d;
         if (fault && !fault_sticky_q) begin
            fault_sticky_q <= 1'b1;
            fault_addr_q   <= bus.Address;
         end
      end
   end

   assign bus.DataRd      = (out_of_range || misaligned || !legal) ? 32'h0 : ext_data;
   assign bus.Misaligned  = misaligned;
   assign bus.OutOfRange  = out_of_range;
   assign bus.FaultSticky = fault_sticky_q;
   assign bus.FaultAddr   = fault_addr_q;

endmodule

// File: tb/tb_data_memory.sv
// -----------------------------------------------------------------------------
// tb_data_memory : directed bench for data_memory (DEPTH=256, BASE_ADDR=0).
// Expected values are hand-computed; expectations for the misalignment steps
// follow DM_MISALIGN_TRAP_EN.
// -----------------------------------------------------------------------------
module tb_data_memory;
   import dm_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   data_memory_if bus ();

   data_memory #(
      .DEPTH     (256),
      .BASE_ADDR (32'h0000_0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // Present an access and let the combinational outputs settle.
   task automatic drive(input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] d, input logic w);
      bus.DMCtrl  = c;
      bus.Address = a;
      bus.DataWr  = d;
      bus.DMWr    = w;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      bus.DMWr = 1'b0;
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      drive(DM_W, 32'h0, 32'h0, 1'b0);
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_sticky", {31'h0, bus.FaultSticky}, 32'h0);
      chk("rst_faddr", bus.FaultAddr, 32'h0);
      drive(DM_W, 32'h10, 32'h0, 1'b0);
      chk("rst_lw10", bus.DataRd, 32'h0);

      // Store then reset (with a store attempted during reset)
      drive(DM_W, 32'h10, 32'hDEADBEEF, 1'b1);
      tick();
      drive(DM_W, 32'h10, 32'h0, 1'b0);
      chk("sw_lw10", bus.DataRd, 32'hDEADBEEF);
      rst = 1'b1;
      drive(DM_W, 32'h10, 32'h12345678, 1'b1);
      tick();
      rst = 1'b0;
      drive(DM_W, 32'h10, 32'h0, 1'b0);
      chk("rst_clr_lw10", bus.DataRd, 32'h0);
      chk("rst_clr_sticky", {31'h0, bus.FaultSticky}, 32'h0);

      // Byte lanes, with read-during-write showing old data before the edge
      drive(DM_W, 32'h20, 32'h11223344, 1'b1);
      tick();
      drive(DM_B, 32'h21, 32'hFFFFFFAA, 1'b1);
      chk("rdw_old_lb21", bus.DataRd, 32'h00000033);
      tick();
      drive(DM_W, 32'h20, 32'h0, 1'b0);
      chk("sb_lw20", bus.DataRd, 32'h1122AA44);
      drive(DM_B, 32'h21, 32'h0, 1'b0);
      chk("lb21", bus.DataRd, 32'hFFFFFFAA);
      drive(DM_BU, 32'h21, 32'h0, 1'b0);
      chk("lbu21", bus.DataRd, 32'h000000AA);
      drive(DM_B, 32'h23, 32'h0, 1'b0);
      chk("lb23", bus.DataRd, 32'h00000011);
      drive(DM_HU, 32'h22, 32'h0, 1'b0);
      chk("lhu22", bus.DataRd, 32'h00001122);

      // Halves
      drive(DM_H, 32'h32, 32'hABCD8001, 1'b1);
      tick();
      drive(DM_H, 32'h32, 32'h0, 1'b0);
      chk("lh32", bus.DataRd, 32'hFFFF8001);
      drive(DM_HU, 32'h32, 32'h0, 1'b0);
      chk("lhu32", bus.DataRd, 32'h00008001);
      drive(DM_W, 32'h30, 32'h0, 1'b0);
      chk("lw30", bus.DataRd, 32'h80010000);
      drive(DM_H, 32'h33, 32'h0, 1'b0);
`ifdef DM_MISALIGN_TRAP_EN
      chk("lh33_mis", bus.DataRd, 32'h0);
`else
      chk("lh33_trunc", bus.DataRd, 32'hFFFF8001);
`endif

      // Misaligned word store
      drive(DM_W, 32'h42, 32'hCAFEF00D, 1'b1);
`ifdef DM_MISALIGN_TRAP_EN
      chk("mis_flag", {31'h0, bus.Misaligned}, 32'h1);
`else
      chk("mis_flag", {31'h0, bus.Misaligned}, 32'h0);
`endif
      tick();
      drive(DM_W, 32'h40, 32'h0, 1'b0);
`ifdef DM_MISALIGN_TRAP_EN
      chk("mis_lw40", bus.DataRd, 32'h0);
      chk("mis_sticky", {31'h0, bus.FaultSticky}, 32'h1);
      chk("mis_faddr", bus.FaultAddr, 32'h42);
`else
      chk("mis_lw40", bus.DataRd, 32'hCAFEF00D);
      chk("mis_sticky", {31'h0, bus.FaultSticky}, 32'h0);
`endif

      // Illegal DMCtrl store
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2_sticky", {31'h0, bus.FaultSticky}, 32'h0);
      drive(DM_W, 32'h50, 32'h00000077, 1'b1);
      tick();
      drive(3'b111, 32'h50, 32'h00000099, 1'b1);
      chk("ill_rd", bus.DataRd, 32'h0);
      tick();
      chk("ill_sticky", {31'h0, bus.FaultSticky}, 32'h1);
      chk("ill_faddr", bus.FaultAddr, 32'h50);
      drive(DM_W, 32'h50, 32'h0, 1'b0);
      chk("ill_lw50", bus.DataRd, 32'h00000077);

      // Out of range store, no aliasing, first fault held
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(DM_W, 32'h400, 32'h00000055, 1'b1);
      chk("oor_flag", {31'h0, bus.OutOfRange}, 32'h1);
      chk("oor_rd", bus.DataRd, 32'h0);
      tick();
      chk("oor_sticky", {31'h0, bus.FaultSticky}, 32'h1);
      chk("oor_faddr", bus.FaultAddr, 32'h400);
      drive(DM_W, 32'h0, 32'h0, 1'b0);
      chk("oor_noalias", bus.DataRd, 32'h0);
      drive(DM_W, 32'h404, 32'h00000066, 1'b1);
      tick();
      chk("oor2_faddr", bus.FaultAddr, 32'h400);
      drive(DM_W, 32'h3FC, 32'h12345678, 1'b1);
      chk("top_inrange", {31'h0, bus.OutOfRange}, 32'h0);
      tick();
      drive(DM_W, 32'h3FC, 32'h0, 1'b0);
      chk("top_lw", bus.DataRd, 32'h12345678);
      drive(DM_W, 32'hFFFFFFFC, 32'h0, 1'b0);
      chk("far_oor", {31'h0, bus.OutOfRange}, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
